// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - oversampling UART receiver with majority vote, error flags and output FIFO
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   i_serial_in      asynchronous serial line, idle high
//   i_ready          consumer takes the FIFO head this cycle
//   o_data           FIFO head data (0 when empty)
//   o_valid          FIFO not empty
//   o_parity_err     head frame parity mismatch (0 when empty)
//   o_frame_err      head frame had a stop bit sampled 0 (0 when empty)
//   o_break          head frame: frame error with all data bits 0 (0 when empty)
//   o_overrun        1-cycle pulse: completed frame dropped because FIFO full
//   o_busy           receiver inside a frame (START/DATA/PARITY/STOP)
module uart_rx_os #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_serial_in,
  input  logic                 i_ready,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_break,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW  = $clog2(OVERSAMPLE + 1);
  localparam int BW  = $clog2(DATA_BITS + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int EW  = DATA_BITS + 3;

  localparam logic [TW-1:0] IDX_LO  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] IDX_MID = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] IDX_HI  = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] IDX_END = TW'(OVERSAMPLE);

  // ---------------- input synchronizer ----------------
  logic sync1;
  logic line;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      line  <= 1'b1;
    end else begin
      sync1 <= i_serial_in;
      line  <= sync1;
    end
  end

  // ---------------- sample tick divider ----------------
  logic [DW-1:0] div_cnt;
  logic          tick;

  assign tick = (div_cnt == DW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || tick) div_cnt <= '0;
    else               div_cnt <= div_cnt + DW'(1);
  end

  // ---------------- receive FSM ----------------
  typedef enum logic [2:0] {ARM, IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state;
  logic [TW-1:0]        tick_cnt;   // index of the last tick seen in the current bit window
  logic [TW-1:0]        idx;        // index of the tick being processed now
  logic [1:0]           samp;
  logic [BW-1:0]        bit_cnt;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr;
  logic                 ferr;
  logic                 vote;
  logic                 last_stop;
  logic                 push;
  logic                 push_ferr;
  logic [EW-1:0]        push_entry;

  always_comb begin
    idx        = tick_cnt + TW'(1);
    // third sample is the live line on the resolving tick
    vote       = (samp[0] & samp[1]) | (samp[0] & line) | (samp[1] & line);
    last_stop  = (stop_cnt == 1'(STOP_BITS - 1));
    push       = tick && (state == STOP) && (idx == IDX_HI) && last_stop;
    push_ferr  = ferr | ~vote;
    push_entry = {push_ferr && (shreg == '0), push_ferr, perr, shreg};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ARM;
      tick_cnt <= '0;
      samp     <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
    end else if (tick) begin
      case (state)
        ARM: begin
          if (line) state <= IDLE;
        end
        IDLE: begin
          if (!line) begin
            state    <= START;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
          end
        end
        default: begin
          tick_cnt <= (idx == IDX_END) ? '0 : idx;
          if (idx == IDX_LO)  samp[0] <= line;
          if (idx == IDX_MID) samp[1] <= line;
          case (state)
            START: begin
              if (idx == IDX_HI && vote) state <= IDLE;
              else if (idx == IDX_END)   state <= DATA;
            end
            DATA: begin
              if (idx == IDX_HI) shreg <= {vote, shreg[DATA_BITS-1:1]};
              if (idx == IDX_END) begin
                if (bit_cnt == BW'(DATA_BITS - 1)) state <= (PARITY_EN != 0) ? PARITY : STOP;
                else                               bit_cnt <= bit_cnt + BW'(1);
              end
            end
            PARITY: begin
              if (idx == IDX_HI)  perr  <= (vote != ((^shreg) ^ (PARITY_ODD != 0)));
              if (idx == IDX_END) state <= STOP;
            end
            STOP: begin
              if (idx == IDX_HI) begin
                if (!vote) ferr <= 1'b1;
                // last stop bit: finish immediately so the next start edge is caught
                if (last_stop) state <= push_ferr ? ARM : IDLE;
              end else if (idx == IDX_END) begin
                stop_cnt <= 1'b1;
              end
            end
            default: state <= ARM;
          endcase
        end
      endcase
    end
  end

  assign o_busy = (state == START) || (state == DATA) || (state == PARITY) || (state == STOP);

  // ---------------- output FIFO ----------------
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          pop;
  logic          wr_en;
  logic [EW-1:0] head;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign pop   = (count != '0) && i_ready;
  // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      o_overrun <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      count     <= count + CW'(wr_en) - CW'(pop);
      o_overrun <= push && full && !pop;
    end
  end

  assign head         = mem[rd_ptr];
  assign o_valid      = (count != '0);
  assign o_data       = o_valid ? head[DATA_BITS-1:0] : '0;
  assign o_parity_err = o_valid & head[DATA_BITS];
  assign o_frame_err  = o_valid & head[DATA_BITS+1];
  assign o_break      = o_valid & head[DATA_BITS+2];

endmodule

// File: tb/tb_uart_rx_os.sv
// tb/tb_uart_rx_os.sv - self-checking bench for uart_rx_os (8N1 and 8E2 instances)
module tb_uart_rx_os;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       line_a = 1'b1, line_b = 1'b1;
  logic       ready_a = 1'b0, ready_b = 1'b0;
  logic [7:0] data_a, data_b;
  logic       valid_a, perr_a, ferr_a, brk_a, ovr_a, busy_a;
  logic       valid_b, perr_b, ferr_b, brk_b, ovr_b, busy_b;

  always #5 clk = ~clk;

  uart_rx_os #(
    .CLK_FREQ(1_843_200), .BAUD_RATE(115_200), .OVERSAMPLE(16), .DATA_BITS(8),
    .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u_dut_a (
    .clk(clk), .reset(reset), .i_serial_in(line_a), .i_ready(ready_a),
    .o_data(data_a), .o_valid(valid_a), .o_parity_err(perr_a), .o_frame_err(ferr_a),
    .o_break(brk_a), .o_overrun(ovr_a), .o_busy(busy_a)
  );

  uart_rx_os #(
    .CLK_FREQ(1_843_200), .BAUD_RATE(115_200), .OVERSAMPLE(16), .DATA_BITS(8),
    .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) u_dut_b (
    .clk(clk), .reset(reset), .i_serial_in(line_b), .i_ready(ready_b),
    .o_data(data_b), .o_valid(valid_b), .o_parity_err(perr_b), .o_frame_err(ferr_b),
    .o_break(brk_b), .o_overrun(ovr_b), .o_busy(busy_b)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // expected FIFO entries {break, frame_err, parity_err, data}
  logic [10:0] exp_a[$];
  logic [10:0] exp_b[$];
  logic [10:0] e_a, e_b;
  int          ovr_cnt_a = 0, ovr_cnt_b = 0;
  bit          rnd_ready = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (ovr_a) ovr_cnt_a++;
      if (ovr_b) ovr_cnt_b++;
      if (valid_a && ready_a) begin
        if (exp_a.size() == 0) chk("a_unexpected_entry", 32'(exp_a.size()), 1);
        else begin
          e_a = exp_a.pop_front();
          chk("a_entry", {21'b0, brk_a, ferr_a, perr_a, data_a}, {21'b0, e_a});
        end
      end
      if (valid_b && ready_b) begin
        if (exp_b.size() == 0) chk("b_unexpected_entry", 32'(exp_b.size()), 1);
        else begin
          e_b = exp_b.pop_front();
          chk("b_entry", {21'b0, brk_b, ferr_b, perr_b, data_b}, {21'b0, e_b});
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_ready) begin
      #1;
      ready_a = 1'($urandom_range(0, 1));
      ready_b = 1'($urandom_range(0, 1));
    end
  end

  task automatic set_ready(input logic a, input logic b);
    @(posedge clk);
    #1;
    ready_a = a;
    ready_b = b;
  endtask

  task automatic drive(input int w, input logic v, input int n);
    if (w == 0) line_a = v;
    else        line_b = v;
    repeat (n) @(negedge clk);
  endtask

  // One frame at 16 clocks per bit. Expected entry is derived from what is put on the line.
  task automatic send_frame(input int w, input logic [7:0] d, input logic pflip,
                            input logic s0, input logic s1, input bit expect_it);
    logic        pb;
    logic        fe;
    logic [10:0] e;
    pb = (^d) ^ pflip;
    fe = !s0 || (w == 1 && !s1);
    e  = {fe && (d == 8'h00), fe, (w == 1) ? (pb != (^d)) : 1'b0, d};
    if (expect_it) begin
      if (w == 0) exp_a.push_back(e);
      else        exp_b.push_back(e);
    end
    drive(w, 1'b0, 16);
    for (int i = 0; i < 8; i++) drive(w, d[i], 16);
    if (w == 1) drive(w, pb, 16);
    drive(w, s0, 16);
    if (w == 1) drive(w, s1, 16);
    drive(w, 1'b1, 0);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 3000 && (exp_a.size() != 0 || exp_b.size() != 0); i++) @(negedge clk);
    chk({tag, "_drain_a"}, 32'(exp_a.size()), 0);
    chk({tag, "_drain_b"}, 32'(exp_b.size()), 0);
  endtask

  initial begin
    logic [7:0] d;
    logic       s0, s1, pf;
    int         gap;

    repeat (3) @(negedge clk);
    chk("rst_valid", {31'b0, valid_a}, 0);
    chk("rst_busy", {31'b0, busy_a}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_data_a", {24'b0, data_a}, 0);
    chk("rst_flags_a", {28'b0, perr_a, ferr_a, brk_a, ovr_a}, 0);
    chk("rst_valid_b", {31'b0, valid_b}, 0);
    chk("rst_busy_b", {31'b0, busy_b}, 0);

    // 8N1 0xA5
    set_ready(1'b1, 1'b1);
    send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b1);
    drive(0, 1'b1, 32);
    chk("a5_busy_idle", {31'b0, busy_a}, 0);
    drain("a5");

    // 8E2 0x3C with wrong parity bit
    send_frame(1, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1);
    drive(1, 1'b1, 32);
    drain("par");

    // 4-tick low glitch: false start only
    drive(0, 1'b0, 4);
    chk("glitch_busy", {31'b0, busy_a}, 1);
    drive(0, 1'b1, 32);
    chk("glitch_busy_after", {31'b0, busy_a}, 0);
    chk("glitch_valid", {31'b0, valid_a}, 0);

    // break: 0x00 with stop 0, line held low, then 0x5A
    send_frame(0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(0, 1'b0, 48);
    chk("brk_armed_busy", {31'b0, busy_a}, 0);
    drive(0, 1'b1, 32);
    send_frame(0, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b1);
    drive(0, 1'b1, 32);
    drain("brk");

    // overrun: consumer stalled, 5 frames into a 4-deep FIFO
    set_ready(1'b0, 1'b1);
    ovr_cnt_a = 0;
    for (int k = 1; k <= 4; k++) begin
      send_frame(0, 8'(k), 1'b0, 1'b1, 1'b1, 1'b1);
      drive(0, 1'b1, 8);
    end
    chk("ovr_none_before_5th", 32'(ovr_cnt_a), 0);
    chk("ovr_head_valid", {31'b0, valid_a}, 1);
    chk("ovr_head_data", {24'b0, data_a}, 1);
    send_frame(0, 8'h05, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(0, 1'b1, 16);
    chk("ovr_pulse_count", 32'(ovr_cnt_a), 1);
    set_ready(1'b1, 1'b1);
    drain("ovr");

    // reset in the middle of 0x55
    drive(0, 1'b0, 16);
    for (int i = 0; i < 4; i++) drive(0, (i % 2 == 0) ? 1'b1 : 1'b0, 16);
    reset = 1'b1;
    drive(0, 1'b1, 2);
    reset = 1'b0;
    chk("rst_mid_valid", {31'b0, valid_a}, 0);
    drive(0, 1'b1, 48);
    chk("rst_mid_busy", {31'b0, busy_a}, 0);
    send_frame(0, 8'h66, 1'b0, 1'b1, 1'b1, 1'b1);
    drive(0, 1'b1, 32);
    drain("rst_mid");

    // randomized frames with random consumer stalls
    ovr_cnt_a = 0;
    ovr_cnt_b = 0;
    rnd_ready = 1'b1;
    for (int n = 0; n < 25; n++) begin
      d   = 8'($urandom);
      s0  = ($urandom_range(0, 7) != 0);
      gap = s0 ? $urandom_range(0, 40) : $urandom_range(20, 60);
      send_frame(0, d, 1'b0, s0, 1'b1, 1'b1);
      drive(0, 1'b1, gap);
    end
    for (int n = 0; n < 25; n++) begin
      d   = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      pf  = ($urandom_range(0, 3) == 0);
      s0  = ($urandom_range(0, 7) != 0);
      s1  = ($urandom_range(0, 7) != 0);
      gap = (s0 && s1) ? $urandom_range(0, 40) : $urandom_range(20, 60);
      send_frame(1, d, pf, s0, s1, 1'b1);
      drive(1, 1'b1, gap);
    end
    drive(0, 1'b1, 40);
    rnd_ready = 1'b0;
    set_ready(1'b1, 1'b1);
    drain("rnd");
    chk("rnd_ovr_a", 32'(ovr_cnt_a), 0);
    chk("rnd_ovr_b", 32'(ovr_cnt_b), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

endmodule
